// File: rtl/bus_arbiter_3x1.sv
// bus_arbiter_3x1: three-requester round-robin bus arbiter
// with a per-grant burst cap and a one-cycle re-arbitration bubble.
module bus_arbiter_3x1 #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic        out_ready,
  output logic [2:0]  gnt,
  output logic [1:0]  select,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic [3:0]  beat_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_MAX - 1);

  state_e      state_q;
  logic [1:0]  owner_q;
  logic [1:0]  last_q;
  logic [2:0]  gnt_q;
  logic [1:0]  sel_q;
  logic [3:0]  cnt_q;

  logic [1:0]  o0, o1, o2;
  logic [1:0]  pick_d;
  logic        own_req;
  logic        beat;

  // Search order starts just after the previous owner and wraps.
  always_comb begin
    o0 = 2'd0;
    o1 = 2'd1;
    o2 = 2'd2;
    unique case (last_q)
      2'd0: begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (req[o0])      pick_d = o0;
    else if (req[o1]) pick_d = o1;
    else              pick_d = o2;
  end

  assign own_req   = req[owner_q];
  assign out_valid = (state_q == GRANT) && own_req;
  assign beat      = out_valid && out_ready;

  // Output data follows the registered select.
  always_comb begin
    unique case (select)
      2'b01:   out_data = a1;
      2'b10:   out_data = a2;
      default: out_data = a0;
    endcase
  end

  // Arbitration FSM with registered grant, select and beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      gnt_q   <= 3'b000;
      sel_q   <= 2'b00;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            owner_q <= pick_d;
            sel_q   <= pick_d;
            gnt_q   <= 3'(3'b001 << pick_d);
            cnt_q   <= 4'd0;
          end
        end
        GRANT: begin
          if (!own_req || (beat && cnt_q == LAST_BEAT)) begin
            state_q <= IDLE;
            last_q  <= owner_q;
            gnt_q   <= 3'b000;
            sel_q   <= 2'b00;
            cnt_q   <= 4'd0;
          end else if (beat) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign select   = sel_q;
  assign beat_cnt = cnt_q;

endmodule

// File: doc/bus_arbiter_3x1.md
BUS_ARBITER_3X1 -- requirements
Module: bus_arbiter_3x1

Interface
REQ-001 Parameter: BURST_MAX, default 4, maximum beats one owner may transfer per grant (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  3  per-requester request; bit i belongs to requester i.
REQ-005 a0  input  32  requester 0 data.
REQ-006 a1  input  32  requester 1 data.
REQ-007 a2  input  32  requester 2 data.
REQ-008 out_ready  input  1  downstream accepts a beat this cycle.
REQ-009 gnt  output  3  one-hot grant, registered; 3'b000 when no owner.
REQ-010 select  output  2  registered mux select: 2'b00/01/10 for owner 0/1/2; 2'b00 when no owner; 2'b11 never driven.
REQ-011 out_data  output  32  a0/a1/a2 chosen by select, combinational.
REQ-012 out_valid  output  1  beat offered: state GRANT and req[owner] high, combinational.
REQ-013 beat_cnt  output  4  beats transferred in the current grant, registered.

Function
REQ-014 States: IDLE (no owner) and GRANT (owner held in a 2-bit register); no other states.
REQ-015 Beat: cycle with out_valid=1 and out_ready=1; only beats increment beat_cnt.
REQ-016 IDLE, req==0: stay IDLE; gnt=0, select=0, beat_cnt=0.
REQ-017 IDLE, req!=0: next edge enters GRANT with owner = first requester with req high, searching from (last_owner+1) mod 3 upward with wrap; gnt/select/owner load on that same edge, beat_cnt cleared to 0.
REQ-018 Arbitration latency: exactly 1 cycle from req sampled high in IDLE to gnt high.
REQ-019 GRANT, req[owner] low: next edge returns to IDLE, last_owner <= owner, gnt <= 0, select <= 0, beat_cnt <= 0; no beat that cycle.
REQ-020 GRANT, beat with beat_cnt==BURST_MAX-1: next edge returns to IDLE as in REQ-019 (burst cap; owner must re-arbitrate).
REQ-021 GRANT, beat with beat_cnt<BURST_MAX-1: beat_cnt increments, owner held.
REQ-022 GRANT, req[owner] high and out_ready low: hold all state; out_data stable, out_valid stays 1.
REQ-023 Requests from non-owners during GRANT are ignored; they win only after return to IDLE.
REQ-024 Each grant is followed by at least one IDLE cycle (re-arbitration bubble); the arbiter never switches owner without IDLE between.
REQ-025 Fairness: with all three req held high, grant order is 0,1,2,0,... each receiving BURST_MAX beats when out_ready=1.
REQ-026 gnt is always one-hot or zero and always consistent with select.

Reset
REQ-027 rst_n low asynchronously forces IDLE, gnt=0, select=2'b00, beat_cnt=0, last_owner=2 (requester 0 highest priority after reset).
REQ-028 Reset asserted mid-burst aborts the burst immediately; no beat is counted in that cycle; after release arbitration restarts from REQ-017 with last_owner=2.
REQ-029 out_valid is 0 while rst_n is low, regardless of req.

Verification
REQ-030 Reset release, req=3'b111, out_ready=1, BURST_MAX=4 -> gnt 001 for 4 beats, IDLE 1 cycle, 010 for 4 beats, IDLE, 100 for 4 beats, IDLE, 001.
REQ-031 req=3'b010 only, a1=32'hDEAD_BEEF, out_ready=1 -> 1 cycle later gnt=010, select=01, out_data=32'hDEADBEEF, out_valid=1.
REQ-032 Owner 2 granted, out_ready=0 for 5 cycles then 1 -> beat_cnt holds 0 during stall, then counts 0,1,2,3, IDLE after 4th beat.
REQ-033 Owner 0 drops req after 2 beats while req[1] high -> IDLE next edge with beat_cnt=0, then gnt=010 following edge.
REQ-034 rst_n pulsed low at beat_cnt=2 of owner 1 -> gnt=000, select=00, beat_cnt=0 asynchronously; after release with req=3'b011 owner 0 wins.
REQ-035 Random req/out_ready for 10k cycles -> gnt never multi-hot, select never 11, no beat exceeds BURST_MAX per grant, every continuously requesting requester granted within 2 other grants.
